jtag_scan_sequencer: RTL
========================

// Module: jtag_scan_sequencer
// PURPOSE
//  Hardware JTAG master. It turns IR/DR scan commands into TCK/TMS/TDI/TRSTn waveforms
//  and returns the captured TDO bits. It sits in the simulation/test top, in place of or
//  beside the socket-driven JTAG bridge, and drives the SoC debug TAP (tck/tms/tdi/trst_n/tdo).
//  This allows self-checking debug-module access without an external OpenOCD.
// PARAMETERS
//  TCK_DIV  4   clk_i cycles per TCK half-period; legal range >=1
//  MAX_LEN  64  maximum scan length in bits; sets the cmd_tdi/rsp_tdo width
// PORTS
//  clk_i        in   1        system clock
//  rst_ni       in   1        reset, asynchronous, active-low
//  cmd_valid_i  in   1        command valid
//  cmd_ready_o  out  1        command accepted when valid & ready
//  cmd_is_ir_i  in   1        1 = IR scan, 0 = DR scan
//  cmd_len_i    in   $clog2(MAX_LEN+1)  scan length in bits
//  cmd_tdi_i    in   MAX_LEN  shift data; bit0 shifted first
//  rsp_valid_o  out  1        response valid
//  rsp_ready_i  in   1        response consumed when valid & ready
//  rsp_tdo_o    out  MAX_LEN  captured TDO; bit i = i-th bit shifted out; bits >= len are 0
//  rsp_err_o    out  1        command rejected; no scan performed
//  tck_o/tms_o/tdi_o  out 1   JTAG drive signals
//  trst_no      out  1        TAP reset, active-low
//  tdo_i        in   1        JTAG TDO from the target
// BEHAVIOUR
//  Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
//  Reset values:
//   - tck_o=0, tms_o=1, tdi_o=0, trst_no=0
//   - cmd_ready_o=0, rsp_valid_o=0, rsp_tdo_o=0, rsp_err_o=0
//   - FSM in TAP_RST
//  TCK generation:
//   - Each TCK half-period is TCK_DIV clk_i cycles.
//   - TMS and TDI change only on the clk_i edge where TCK falls (or while TCK is low).
//   - TDO is sampled on the clk_i edge where TCK rises.
//   - When no TCK cycle is pending, TCK is parked low.
//  FSM (each TMS step = one full TCK cycle):
//   - TAP_RST: deassert trst_n on the first cycle. Clock 5x TMS=1, then 1x TMS=0, then go to IDLE.
//     The TAP ends in Run-Test/Idle.
//   - IDLE: cmd_ready_o=1.
//     - On accept: latch the command. If len==0 or len>MAX_LEN, go to RSP with err=1 and no TCK.
//     - Otherwise go to SEL.
//   - SEL: TMS sequence 1,0,0 for DR; 1,1,0,0 for IR. Reaches Shift-xR.
//   - SHIFT: len TCK cycles.
//     - tdi_o = data[bit_cnt].
//     - TMS=0 on every bit except the last, which uses TMS=1 (enters Exit1).
//     - rsp_tdo[bit_cnt] is loaded on each rising edge.
//   - UPD: TMS sequence 1,0 (Update-xR, then Run-Test/Idle).
//   - RSP: rsp_valid_o=1; outputs held stable until rsp_ready_i. Return to IDLE on handshake.
//     TCK stays low throughout.
//  Latency, accept to rsp_valid (legal command):
//   - DR: (3+len+2)*2*TCK_DIV + 1 clk.
//   - IR: (4+len+2)*2*TCK_DIV + 1 clk.
//   - Error: 1 clk.
//  Handshake rules:
//   - cmd_ready_o is 0 in every state except IDLE.
//   - cmd_valid_i is ignored when not ready.
//   - The response is not dropped under backpressure.
//  Boundaries:
//   - len==1: the single bit is shifted with TMS=1.
//   - len==MAX_LEN: bit_cnt must not overflow. Use a counter of width $clog2(MAX_LEN+1).
//   - rsp_valid and a new cmd never overlap: one outstanding command at a time.
//   - Reset mid-scan: all outputs return to their reset values immediately (asynchronously).
//     After release, TAP_RST runs again; any partial scan is discarded.
//   - TCK_DIV==1: TCK toggles every clk_i cycle. The TDO sample and TMS update still occur on
//     distinct edges.
// STRUCTURE
//  Shared package jtag_seq_pkg:
//   - state_e enum
//   - TMS_TLR_SEQ, TMS_SEL_DR, TMS_SEL_IR, TMS_UPD constants
//   - TLR_CLOCKS=5
//  Sub-module jtag_tck_gen:
//   - half-period counter
//   - drives tck_o
//   - emits tck_rise_o/tck_fall_o strobes and takes a run_i request
//  The sequencer FSM, shift register and bit counter form the top module.
// TESTING
//  1. Reset release, TCK_DIV=4: exactly 6 TCK pulses with TMS=1,1,1,1,1,0; trst_no goes high;
//     cmd_ready_o rises after 48+ clks.
//  2. DR scan, len=32, tdi=0, TAP model in IDCODE: rsp_tdo_o[31:0]=0x249511C3, err=0;
//     TMS trace is 1,0,0, then 0x31, then 1, then 1,0.
//  3. IR scan, len=5, tdi=0x11: model IR=0x11; rsp_tdo_o[4:0]=0x01 (capture pattern);
//     TMS prefix is 1,1,0,0.
//  4. len=0, and separately len=MAX_LEN+1: rsp_valid 1 clk after accept, rsp_err_o=1,
//     no TCK edge.
//  5. rsp_ready_i held low for 100 clks after valid: rsp_valid/rsp_tdo stable,
//     cmd_ready_o=0, TCK low.
//  6. rst_ni low in the middle of a 64-bit DR shift: outputs reach reset values within the same
//     cycle; after release, TAP_RST is repeated and the next IDCODE scan is correct.

Source files
------------

// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: shared FSM states and TMS step sequences for the JTAG scan sequencer.
// Sequences are stored LSB-first: bit i is the TMS value of step i.
package jtag_seq_pkg;
   typedef enum logic [2:0] {TAP_RST, IDLE, SEL, SHIFT, UPD, RSP} state_e;
   localparam int TLR_CLOCKS = 5;
   localparam logic [7:0] TMS_TLR_SEQ = 8'b0001_1111;
   localparam logic [7:0] TMS_SEL_DR = 8'b0000_0001;
   localparam logic [7:0] TMS_SEL_IR = 8'b0000_0011;
   localparam logic [7:0] TMS_UPD = 8'b0000_0001;
   function automatic logic seq_bit(input logic [7:0] seq, input logic [2:0] idx);
      return seq[idx];
   endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk_i down to TCK and flags the clk_i edges where TCK rises or falls.
module jtag_tck_gen #(
   parameter int TCK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run_i,
   output logic tck_o,
   output logic tck_rise_o,
   output logic tck_fall_o
);
   localparam int CW = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TCK_DIV - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic tck_q, tck_d, active, wrap;
   // A started TCK cycle always completes, so TCK only ever parks low.
   assign active = run_i | tck_q;
   assign wrap = active & (cnt_q == CNT_MAX);
   assign tck_rise_o = wrap & ~tck_q;
   assign tck_fall_o = wrap & tck_q;
   assign tck_o = tck_q;
   always_comb begin
      cnt_d = (wrap || !active) ? '0 : cnt_q + 1'b1;
      tck_d = wrap ? ~tck_q : tck_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end
endmodule

// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: hardware JTAG master turning IR/DR scan commands into
// TCK/TMS/TDI/TRSTn waveforms and returning the captured TDO bits.
module jtag_scan_sequencer
   import jtag_seq_pkg::*;
#(
   parameter int TCK_DIV = 4,
   parameter int MAX_LEN = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         cmd_valid_i,
   output logic                         cmd_ready_o,
   input  logic                         cmd_is_ir_i,
   input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len_i,
   input  logic [MAX_LEN-1:0]           cmd_tdi_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [MAX_LEN-1:0]           rsp_tdo_o,
   output logic                         rsp_err_o,
   output logic                         tck_o,
   output logic                         tms_o,
   output logic                         tdi_o,
   output logic                         trst_no,
   input  logic                         tdo_i
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int CW = LW > 3 ? LW : 3;
   state_e state_q, state_d, nxt;
   logic [CW-1:0] cnt_q, cnt_d, last_idx;
   logic [LW-1:0] len_q, len_d;
   logic [MAX_LEN-1:0] sh_q, sh_d, tdo_q, tdo_d;
   logic ir_q, ir_d, err_q, err_d, trst_q;
   logic run, tck_rise, tck_fall, last, bad_len;
   jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .run_i      (run),
      .tck_o      (tck_o),
      .tck_rise_o (tck_rise),
      .tck_fall_o (tck_fall)
   );
   assign run = trst_q & (state_q != IDLE) & (state_q != RSP);
   assign bad_len = (cmd_len_i == '0) || (cmd_len_i > LW'(MAX_LEN));
   // cnt_q counts TMS steps outside SHIFT and data bits inside it.
   assign last_idx = state_q == TAP_RST ? CW'(TLR_CLOCKS) :
                     state_q == SEL     ? (ir_q ? CW'(3) : CW'(2)) :
                     state_q == SHIFT   ? CW'(len_q) - CW'(1) : CW'(1);
   assign last = cnt_q == last_idx;
   assign nxt = state_q == TAP_RST ? IDLE : state_q == SEL ? SHIFT : state_q == SHIFT ? UPD : RSP;
   assign tms_o = state_q == TAP_RST ? seq_bit(TMS_TLR_SEQ, cnt_q[2:0]) :
                  state_q == SEL     ? seq_bit(ir_q ? TMS_SEL_IR : TMS_SEL_DR, cnt_q[2:0]) :
                  state_q == SHIFT   ? last :
                  state_q == UPD     ? seq_bit(TMS_UPD, cnt_q[2:0]) : 1'b0;
   assign tdi_o = (state_q == SHIFT) & sh_q[0];
   assign trst_no = trst_q;
   assign cmd_ready_o = state_q == IDLE;
   assign rsp_valid_o = state_q == RSP;
   assign rsp_tdo_o = tdo_q;
   assign rsp_err_o = (state_q == RSP) & err_q;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      len_d = len_q;
      ir_d = ir_q;
      sh_d = sh_q;
      tdo_d = tdo_q;
      err_d = err_q;
      if (state_q == IDLE) begin
         if (cmd_valid_i) begin
            len_d = cmd_len_i;
            ir_d = cmd_is_ir_i;
            sh_d = cmd_tdi_i;
            tdo_d = '0;
            cnt_d = '0;
            err_d = bad_len;
            state_d = bad_len ? RSP : SEL;
         end
      end else if (state_q == RSP) begin
         if (rsp_ready_i) state_d = IDLE;
      end else begin
         if (tck_rise && state_q == SHIFT) tdo_d = tdo_q | ({{(MAX_LEN-1){1'b0}}, tdo_i} << cnt_q);
         if (tck_fall) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (state_q == SHIFT) sh_d = sh_q >> 1;
            if (last) state_d = nxt;
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= TAP_RST;
         cnt_q <= '0;
         len_q <= '0;
         ir_q <= 1'b0;
         sh_q <= '0;
         tdo_q <= '0;
         err_q <= 1'b0;
         trst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         ir_q <= ir_d;
         sh_q <= sh_d;
         tdo_q <= tdo_d;
         err_q <= err_d;
         trst_q <= 1'b1;
      end
   end
endmodule
